regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, 2-read, 32x32 register file in the decode/writeback stages.
- Generalises register width, register count, and read/write port count.
- Adds a hardwired zero register and deterministic write-port priority.
- Adds an optional write-to-read bypass.
- Replaces the one-cycle array reset with a sequential clear engine, which also serves software/pipeline flush requests.

Parameters:
- XLEN, 32: register width in bits.
- NREGS, 32: number of registers. Must be a power of 2, at least 4. Entry 0 is hardwired to zero.
- NRP, 2: number of read ports (1..4).
- NWP, 2: number of write ports (1..2).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low. Sampled on the rising clk edge; asserted when 0.
- we  in  NWP  per-port write enable.
- waddr  in  NWP*AW  packed write addresses; AW = clog2(NREGS); port i occupies slice [i*AW +: AW].
- wdata  in  NWP*XLEN  packed write data.
- raddr  in  NRP*AW  packed read addresses.
- rdata  out  NRP*XLEN  packed read data, combinational from raddr.
- clr_req  in  1  single-cycle request to zero the whole file.
- busy  out  1  clear engine active; writes ignored and reads return 0 while high.

Behaviour:
- Storage covers entries 1..NREGS-1 only. Entry 0 is not stored: reads of address 0 return 0, and writes to 0 are dropped.
- Writes commit on the clock edge when we[i]=1, busy=0, rst=1, and waddr != 0.
- Two write ports targeting the same address in one cycle: the higher port index wins; the lower write is discarded.
- Reads are combinational with zero latency. A read returns contents as of the last edge, except as modified by the bypass (Optional Feature).
- busy=1 forces every rdata lane to 0.
- Clear FSM, states IDLE and CLEAR, with pointer ptr of width AW:
  - rst=0 on an edge → state=CLEAR, ptr=1; busy=1 from the next cycle and throughout reset.
  - CLEAR: each edge writes 0 to entry ptr and increments ptr. When ptr=NREGS-1 is written, go to IDLE.
  - Clear therefore takes NREGS-1 cycles after rst release: busy high for exactly NREGS-1 cycles, low on cycle NREGS.
  - IDLE with clr_req=1 → CLEAR, ptr=1. busy rises the following cycle.
  - Write ports are ignored on the clr_req cycle itself only if busy is already high; otherwise they commit normally.
  - clr_req during CLEAR is ignored; no restart and no queueing.
  - rst=0 mid-clear restarts at ptr=1 and re-runs the full NREGS-1 cycles.
- Reset values: busy=1, state=CLEAR, ptr=1, rdata=0.
- No X is ever driven on rdata after the first reset edge.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: a read lane whose raddr matches an active, committing write (we=1, busy=0, addr != 0) in the same cycle returns that write's wdata combinationally.
  - If both write ports match, the higher port index is forwarded, consistent with write priority.
- Undefined: reads in the write cycle return the pre-write contents; the new value is visible from the next cycle.
  - No combinational path from we/waddr/wdata to rdata.

Decomposition:
- Package rf_pkg holds:
  - the state enum rf_clr_state_e {RF_IDLE, RF_CLEAR};
  - the address-width helper function rf_aw(nregs);
  - the constant RF_ZERO_ADDR = 0.
- Sub-module rf_clear_fsm owns state, ptr, and busy, and outputs clr_we/clr_addr to the array.
- Top module regfile_mp owns the storage array, write-priority mux, read mux, and bypass.

Test Plan:
- Reset then release: hold rst=0 for 3 cycles, then release → busy=1 for exactly 31 cycles, then 0. All 32 addresses read 0x00000000 afterwards.
- Basic write and zero register:
  - we0, waddr0=5, wdata0=0xDEADBEEF; next cycle raddr0=5 → 0xDEADBEEF.
  - Write x0=0x1234 → raddr=0 reads 0.
- Port conflict: same cycle we0 x7=0x11111111 and we1 x7=0x22222222 → x7 reads 0x22222222.
- Same-cycle read of a write:
  - Setup: x3=0x0F0F0F0F; then we0 x3=0xA5A5A5A5 with raddr1=3 in the same cycle.
  - With REGFILE_MP_BYPASS_EN → rdata1=0xA5A5A5A5.
  - Without REGFILE_MP_BYPASS_EN → 0x0F0F0F0F, then 0xA5A5A5A5 next cycle.
- Flush:
  - Fill x1..x31 with their index; pulse clr_req → busy high for 31 cycles.
  - Write x9=0x99 during busy → dropped; all registers read 0 after busy falls.
- Reset mid-clear: assert clr_req, drive rst=0 for one edge at ptr=10 → busy stays high for 31 full cycles after release.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared types and helpers for the multi-port register file.
package rf_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_clr_state_e;
  localparam int RF_ZERO_ADDR = 0;
  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction
endpackage

// File: rtl/rf_clear_fsm.sv
// rf_clear_fsm: sequential clear engine; walks entries 1..NREGS-1 writing zero on reset or clr_req.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  rf_clr_state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == RF_IDLE) begin
      state_d = clr_req ? RF_CLEAR : RF_IDLE;
      ptr_d   = clr_req ? AW'(1) : ptr_q;
    end else begin
      ptr_d   = ptr_q + AW'(1);
      state_d = (ptr_q == AW'(NREGS - 1)) ? RF_IDLE : RF_CLEAR;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RF_CLEAR;
      ptr_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  assign busy     = (state_q == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with hardwired x0 and a sequential clear engine.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle committing writes to the read ports.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  parameter int NWP   = 2,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   waddr,
  input  logic [NWP*XLEN-1:0] wdata,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  input  logic                clr_req,
  output logic                busy
);
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic [AW-1:0]   wa [NWP];
  logic [XLEN-1:0] wd [NWP];
  logic [NWP-1:0]  wr_en;
  logic [XLEN-1:0] mem_q [1:NREGS-1];
  logic [XLEN-1:0] mem_d [1:NREGS-1];

  rf_clear_fsm #(.NREGS(NREGS), .AW(AW)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  for (genvar w = 0; w < NWP; w++) begin : g_wp
    assign wa[w]    = waddr[w*AW +: AW];
    assign wd[w]    = wdata[w*XLEN +: XLEN];
    assign wr_en[w] = we[w] & ~busy & rst & (wa[w] != AW'(RF_ZERO_ADDR));
  end

  // Later ports overwrite earlier ones, giving the higher index priority.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NWP; i++)
      if (wr_en[i]) mem_d[wa[i]] = wd[i];
    if (clr_we) mem_d[clr_addr] = '0;
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  for (genvar r = 0; r < NRP; r++) begin : g_rp
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;
    always_comb begin
      ra = raddr[r*AW +: AW];
      rv = (ra == AW'(RF_ZERO_ADDR)) ? '0 : mem_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
      for (int i = 0; i < NWP; i++)
        if (wr_en[i] && wa[i] == ra) rv = wd[i];
`endif
    end
    assign rdata[r*XLEN +: XLEN] = busy ? '0 : rv;
  end
endmodule
